spec_chan_array: RTL
====================

Name: spec_chan_array

Overview:
- Parametrised successor of the fixed ten-instance synthetic test top.
- Instantiates NUM_CH identical, independently enabled handshake-tracking channels. Each channel has a 2-bit stimulus input and a 2-bit registered Moore output.
- Adds what the fixed top lacks:
  - asynchronous reset
  - per-channel enable
  - pulse/sticky completion mode
  - configurable arming depth
  - saturating per-channel completion counters
- Serves as the scalable DUT for trace generation and property mining in the synthetic suite.

Parameters:
- NUM_CH, 10, number of channels (>=1)
- DEPTH, 3, consecutive a[0]=1 cycles required in WAIT before RUN (>=1)
- CNT_W, 4, width of each per-channel completion counter (>=1)

Ports:
- clock  input  1  single rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- a  input  2*NUM_CH  channel i stimulus at a[2i+1:2i]; bit0 = req, bit1 = ack/abort
- en  input  NUM_CH  per-channel enable; 0 freezes that channel
- mode  input  1  global; 0 = DONE pulses one cycle, 1 = DONE sticky
- clr_cnt  input  1  synchronous clear of all completion counters
- c  output  2*NUM_CH  channel i state code at c[2i+1:2i]
- done_cnt  output  CNT_W*NUM_CH  channel i saturating count of DONE entries
- busy  output  NUM_CH  1 when channel i is in WAIT or RUN

Behaviour:
- One clock, named clock. Reset is asynchronous and active-low on reset_n.
- Reset values, all channels: state IDLE, c=00, arm counter 0, done_cnt 0, busy 0. Reset asserted mid-operation aborts immediately to these values.
- Moore outputs: c and busy decode the state register only. Latency is one cycle from the input sample to the c change.
- State codes (c): IDLE=00, WAIT=01, RUN=10, DONE=11.
- Transitions, evaluated only when en[i]=1; when en[i]=0, state, arm counter and done_cnt hold.
- IDLE:
  - a==01 -> WAIT, arm counter cleared.
  - any other value -> stay.
- WAIT, in priority order:
  - a[1]=1 -> IDLE (abort).
  - a[0]=1 with arm counter == DEPTH-1 -> RUN.
  - a[0]=1 otherwise -> arm counter +1.
  - a[0]=0 -> arm counter cleared, stay in WAIT.
  - The cycle of entry into WAIT does not count toward DEPTH.
  - With DEPTH=1, the first qualifying cycle in WAIT goes straight to RUN.
- RUN:
  - a==10 -> DONE.
  - a==11 -> IDLE (abort).
  - otherwise stay.
- DONE:
  - mode=0 -> IDLE next cycle, regardless of a.
  - mode=1 -> stay until a==11, then IDLE.
  - mode changing while in DONE takes effect on the next evaluation.
- Arm counter width is $clog2(DEPTH+1). It never exceeds DEPTH-1.
- done_cnt[i]:
  - +1 on each RUN->DONE transition.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 clears all counters next cycle and beats a simultaneous increment (result 0).
  - clr_cnt acts even when en[i]=0.
- Channels share no state. Simultaneous events on different channels are fully independent.

Decomposition:
- Shared package spec_array_pkg:
  - state enum, 2-bit, with the codes above
  - localparams for abort and advance stimulus codes (A_START=01, A_DONE=10, A_ABORT=11)
- One sub-module, spec_chan:
  - contains one channel's FSM, arm counter and saturating counter
  - parameters DEPTH and CNT_W
  - instantiated NUM_CH times via generate, slicing the flattened buses

Test Plan:
- Reset/idle: reset_n=0 mid-RUN on ch3 -> c=00 and done_cnt=0 on all channels immediately; after release with a=0, c stays all-zero.
- Nominal (DEPTH=3, mode=0), ch0 driven 01, then 01,01,01, then 10 -> c goes 01, stays 01 for 2 cycles, then 10, 11 for exactly one cycle, then 00; done_cnt[0]=1; busy[0] high only during WAIT and RUN.
- Arm restart and abort: in WAIT, drive 01,00,01,01,01 -> RUN reached only after the final three consecutive 01s. Separately, 11 in WAIT or in RUN -> IDLE next cycle, done_cnt unchanged.
- Sticky and enable: mode=1, reach DONE; hold a=00 for 5 cycles -> c stays 11; drive 11 -> c=00. Drop en[2] mid-WAIT for 4 cycles -> ch2 c and arm count frozen, other channels progress.
- Saturation and clear (CNT_W=4): complete 17 transactions on ch5 -> done_cnt[5]=15. Assert clr_cnt on the same cycle as a RUN->DONE -> done_cnt[5]=0.
- Scaling: NUM_CH=1 and DEPTH=1 build, and 01 then 01 then 10 -> c goes 01, 10, 11, 00. NUM_CH=32 build: ten independent random channels match a reference model.

Source files
------------

// File: rtl/spec_array_pkg.sv
// Shared types and stimulus codes for the handshake-tracking channel array.
// State codes double as the channel's c output, so their encoding is fixed.
package spec_array_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } chan_state_t;

   localparam logic [1:0] A_START = 2'b01;
   localparam logic [1:0] A_DONE  = 2'b10;
   localparam logic [1:0] A_ABORT = 2'b11;

   function automatic logic is_busy(input chan_state_t s);
      return (s == ST_WAIT) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/spec_chan.sv
// One handshake-tracking channel: Moore FSM, arming counter that requires DEPTH
// consecutive requests, and a saturating completion counter.
module spec_chan
   import spec_array_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [1:0]       a,
   input  logic             en,
   input  logic             mode,
   input  logic             clr_cnt,
   output logic [1:0]       c,
   output logic [CNT_W-1:0] done_cnt,
   output logic             busy
);

   localparam int                ARM_W    = $clog2(DEPTH + 1);
   localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   chan_state_t      state_reg;
   logic [ARM_W-1:0] arm_reg;
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         arm_reg   <= '0;
      end else if (en) begin
         case (state_reg)
            ST_IDLE: begin
               if (a == A_START) begin
                  state_reg <= ST_WAIT;
                  arm_reg   <= '0;
               end
            end
            ST_WAIT: begin
               // Abort outranks arming; a dropped request restarts the streak.
               if (a[1]) begin
                  state_reg <= ST_IDLE;
               end else if (a[0]) begin
                  if (arm_reg == ARM_LAST) state_reg <= ST_RUN;
                  else                     arm_reg   <= arm_reg + 1'b1;
               end else begin
                  arm_reg <= '0;
               end
            end
            ST_RUN: begin
               if (a == A_DONE)       state_reg <= ST_DONE;
               else if (a == A_ABORT) state_reg <= ST_IDLE;
            end
            ST_DONE: begin
               if (!mode || (a == A_ABORT)) state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Clear is global and ignores the channel enable; it also beats an increment.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else if (clr_cnt) begin
         cnt_reg <= '0;
      end else if (en && (state_reg == ST_RUN) && (a == A_DONE) && (cnt_reg != CNT_MAX)) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign c        = state_reg;
   assign busy     = is_busy(state_reg);
   assign done_cnt = cnt_reg;

endmodule

// File: rtl/spec_chan_array.sv
// Array of NUM_CH independent handshake-tracking channels sharing only the
// clock, reset, mode and counter-clear controls.
module spec_chan_array
   import spec_array_pkg::*;
#(
   parameter int NUM_CH = 10,
   parameter int DEPTH  = 3,
   parameter int CNT_W  = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [2*NUM_CH-1:0]     a,
   input  logic [NUM_CH-1:0]       en,
   input  logic                    mode,
   input  logic                    clr_cnt,
   output logic [2*NUM_CH-1:0]     c,
   output logic [CNT_W*NUM_CH-1:0] done_cnt,
   output logic [NUM_CH-1:0]       busy
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         spec_chan #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
         ) u_chan (
            .clock    (clock),
            .reset_n  (reset_n),
            .a        (a[2*gi +: 2]),
            .en       (en[gi]),
            .mode     (mode),
            .clr_cnt  (clr_cnt),
            .c        (c[2*gi +: 2]),
            .done_cnt (done_cnt[CNT_W*gi +: CNT_W]),
            .busy     (busy[gi])
         );
      end
   endgenerate

endmodule
